// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared definitions for the mult/div sequencer.
//   state_e          - sequencer FSM states
//   RSTATUS_*        - codes written to $rstatus on exception / timeout
//   REG_RSTATUS      - architectural index of $rstatus (r30)
package multdiv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StDone
  } state_e;

  localparam int unsigned RSTATUS_MULT    = 4;
  localparam int unsigned RSTATUS_DIV     = 5;
  localparam int unsigned RSTATUS_TIMEOUT = 7;

  localparam logic [4:0] REG_RSTATUS = 5'd30;

endpackage

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequences one mult/div operation through the iterative multdiv unit.
//   clock, reset (sync, active-low)
//   issue_*        - mult/div request from execute (operands, op select, rd)
//   flush          - squash the in-flight operation
//   md_result, md_exception, md_rdy - completion from multdiv
//   ctrl_MULT/ctrl_DIV - one-cycle start pulses; md_a/md_b - latched operands
//   stall          - hold the front of the pipeline while an op is outstanding
//   result_valid/result_data/result_reg - one-cycle writeback strobe
//   busy           - sequencer not idle
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic             issue_is_mult,
  input  logic             issue_is_div,
  input  logic [WIDTH-1:0] issue_a,
  input  logic [WIDTH-1:0] issue_b,
  input  logic [4:0]       issue_rd,
  input  logic             flush,
  input  logic [WIDTH-1:0] md_result,
  input  logic             md_exception,
  input  logic             md_rdy,
  output logic             ctrl_MULT,
  output logic             ctrl_DIV,
  output logic [WIDTH-1:0] md_a,
  output logic [WIDTH-1:0] md_b,
  output logic             stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] result_data,
  output logic [4:0]       result_reg,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e            r_state, w_state_next;
  logic [CntW-1:0]   r_cnt;
  logic              r_is_mult;
  logic [WIDTH-1:0]  r_a, r_b;
  logic [4:0]        r_rd;
  logic [WIDTH-1:0]  r_res_data;
  logic [4:0]        r_res_reg;

  logic w_qual;
  logic w_accept;
  logic w_capture;
  logic w_timeout;

  assign w_qual = issue_valid & (issue_is_mult | issue_is_div);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    unique case (r_state)
      StIdle: begin
        // Completions seen here belong to abandoned ops and are dropped.
        if (w_qual) begin
          w_state_next = StStart;
          w_accept     = 1'b1;
        end
      end
      StStart: begin
        w_state_next = flush ? StIdle : StWait;
      end
      StWait: begin
        // Flush wins over a same-cycle completion.
        if (flush) begin
          w_state_next = StIdle;
        end else if (md_rdy) begin
          w_state_next = StDone;
          w_capture    = 1'b1;
        end else if (r_cnt == CntW'(TIMEOUT - 1)) begin
          w_state_next = StDone;
          w_timeout    = 1'b1;
        end
      end
      StDone: begin
        if (w_qual) begin
          w_state_next = StStart;
          w_accept     = 1'b1;
        end else begin
          w_state_next = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_is_mult  <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_rd       <= '0;
      r_res_data <= '0;
      r_res_reg  <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_accept) begin
        r_is_mult <= issue_is_mult;  // mult takes priority when both are set
        r_a       <= issue_a;
        r_b       <= issue_b;
        r_rd      <= issue_rd;
      end

      if (r_state == StStart) begin
        r_cnt <= '0;
      end else if (r_state == StWait && r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_capture) begin
        if (md_exception) begin
          r_res_reg  <= REG_RSTATUS;
          r_res_data <= r_is_mult ? WIDTH'(RSTATUS_MULT) : WIDTH'(RSTATUS_DIV);
        end else begin
          r_res_reg  <= r_rd;
          r_res_data <= md_result;
        end
      end else if (w_timeout) begin
        r_res_reg  <= REG_RSTATUS;
        r_res_data <= WIDTH'(RSTATUS_TIMEOUT);
      end
    end
  end

  always_comb begin
    ctrl_MULT    = (r_state == StStart) &  r_is_mult;
    ctrl_DIV     = (r_state == StStart) & ~r_is_mult;
    md_a         = r_a;
    md_b         = r_b;
    // Low in DONE so the X/M latch can take the result.
    stall        = ((r_state == StIdle) & w_qual) | (r_state == StStart) | (r_state == StWait);
    result_valid = (r_state == StDone);
    result_data  = (r_state == StDone) ? r_res_data : '0;
    result_reg   = (r_state == StDone) ? r_res_reg  : '0;
    busy         = (r_state != StIdle);
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
module tb_multdiv_ctrl;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TIMEOUT = 40;

  logic             clock = 1'b0;
  logic             reset;
  logic             issue_valid, issue_is_mult, issue_is_div;
  logic [WIDTH-1:0] issue_a, issue_b;
  logic [4:0]       issue_rd;
  logic             flush;
  logic [WIDTH-1:0] md_result;
  logic             md_exception, md_rdy;
  logic             ctrl_MULT, ctrl_DIV;
  logic [WIDTH-1:0] md_a, md_b;
  logic             stall, result_valid, busy;
  logic [WIDTH-1:0] result_data;
  logic [4:0]       result_reg;

  multdiv_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clock        (clock),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_is_mult(issue_is_mult),
    .issue_is_div (issue_is_div),
    .issue_a      (issue_a),
    .issue_b      (issue_b),
    .issue_rd     (issue_rd),
    .flush        (flush),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_rdy       (md_rdy),
    .ctrl_MULT    (ctrl_MULT),
    .ctrl_DIV     (ctrl_DIV),
    .md_a         (md_a),
    .md_b         (md_b),
    .stall        (stall),
    .result_valid (result_valid),
    .result_data  (result_data),
    .result_reg   (result_reg),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an op in flight has an age counted from its start pulse.
  logic             m_busy = 1'b0, m_done = 1'b0, m_mult = 1'b0;
  int               m_age = 0;
  logic [WIDTH-1:0] m_a = '0, m_b = '0, m_rdata = '0;
  logic [4:0]       m_rd = '0, m_rreg = '0;
  logic             q;

  assign q = issue_valid && (issue_is_mult || issue_is_div);

  always @(posedge clock) begin
    if (!reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_age <= 0; m_mult <= 1'b0;
      m_a <= '0; m_b <= '0; m_rd <= '0; m_rdata <= '0; m_rreg <= '0;
    end else if (!m_busy) begin
      m_done <= 1'b0;
      if (q) begin
        m_busy <= 1'b1; m_age <= 0; m_mult <= issue_is_mult;
        m_a <= issue_a; m_b <= issue_b; m_rd <= issue_rd;
      end
    end else if (flush) begin
      m_busy <= 1'b0;
    end else if (m_age > 0 && md_rdy) begin
      m_busy <= 1'b0; m_done <= 1'b1;
      if (md_exception) begin
        m_rreg  <= 5'd30;
        m_rdata <= m_mult ? 32'd4 : 32'd5;
      end else begin
        m_rreg  <= m_rd;
        m_rdata <= md_result;
      end
    end else if (m_age == int'(TIMEOUT)) begin
      // Age 1 is the first WAIT cycle, so this is the TIMEOUT-th WAIT cycle.
      m_busy <= 1'b0; m_done <= 1'b1; m_rreg <= 5'd30; m_rdata <= 32'd7;
    end else begin
      m_age <= m_age + 1;
    end
  end

  // Observation counters used by the per-scenario literal checks.
  bit chk_en = 1'b0;
  int cyc = 0, stall_cnt = 0, pulse_cnt = 0, rv_cnt = 0, pulse_cyc = 0, rv_cyc = 0;
  logic [WIDTH-1:0] rv_data;
  logic [4:0]       rv_reg;

  always @(negedge clock) begin
    if (chk_en) begin
      cyc++;
      chk("ctrl_MULT", ctrl_MULT, m_busy && m_age == 0 && m_mult);
      chk("ctrl_DIV", ctrl_DIV, m_busy && m_age == 0 && !m_mult);
      chk("stall", stall, m_busy || (!m_done && q));
      chk("result_valid", result_valid, m_done);
      chk("busy", busy, m_busy || m_done);
      chk("md_a", md_a, m_a);
      chk("md_b", md_b, m_b);
      if (m_done) begin
        chk("result_data", result_data, m_rdata);
        chk("result_reg", result_reg, m_rreg);
      end
      if (stall) stall_cnt++;
      if (ctrl_MULT || ctrl_DIV) begin
        pulse_cnt++;
        pulse_cyc = cyc;
      end
      if (result_valid) begin
        rv_cnt++;
        rv_cyc  = cyc;
        rv_data = result_data;
        rv_reg  = result_reg;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_obs();
    stall_cnt = 0; pulse_cnt = 0; rv_cnt = 0; pulse_cyc = 0; rv_cyc = 0;
    rv_data = '0; rv_reg = '0;
  endtask

  task automatic issue(input logic m, input logic d, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [4:0] rd);
    issue_valid = 1'b1; issue_is_mult = m; issue_is_div = d;
    issue_a = a; issue_b = b; issue_rd = rd;
  endtask

  task automatic no_issue();
    issue_valid = 1'b0; issue_is_mult = 1'b0; issue_is_div = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {ctrl_MULT, ctrl_DIV, stall, result_valid, busy, md_a, md_b,
               result_data, result_reg}, '0);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; md_result = '0; md_exception = 1'b0; md_rdy = 1'b0;
    issue_a = '0; issue_b = '0; issue_rd = '0;
    no_issue();
    repeat (2) tick();
    chk_en = 1'b1;
    chk_all_zero("reset_outputs");
    reset = 1'b1;
    tick();

    // mult 6x7 -> rd 3, ready in the 33rd cycle counting the pulse cycle as the first
    clr_obs();
    issue(1'b1, 1'b0, 32'd6, 32'd7, 5'd3);
    tick();
    no_issue();
    repeat (32) tick();
    md_rdy = 1'b1; md_result = 32'd42;
    tick();
    md_rdy = 1'b0;
    repeat (2) tick();
    chk("mult_stall_cycles", stall_cnt, 34);
    chk("mult_pulses", pulse_cnt, 1);
    chk("mult_results", rv_cnt, 1);
    chk("mult_data", rv_data, 42);
    chk("mult_reg", rv_reg, 3);

    // div 10/0 with exception; a completion during START is ignored
    clr_obs();
    issue(1'b0, 1'b1, 32'd10, 32'd0, 5'd4);
    tick();
    no_issue();
    md_rdy = 1'b1; md_exception = 1'b1; md_result = 32'd123;
    tick();
    md_rdy = 1'b0; md_exception = 1'b0;
    repeat (2) tick();
    md_rdy = 1'b1; md_exception = 1'b1; md_result = 32'd0;
    tick();
    md_rdy = 1'b0; md_exception = 1'b0;
    tick();
    chk("div_exc_results", rv_cnt, 1);
    chk("div_exc_data", rv_data, 5);
    chk("div_exc_reg", rv_reg, 30);

    // mult overflow, both op bits set (mult wins)
    clr_obs();
    issue(1'b1, 1'b1, 32'h0001_0000, 32'h0001_0000, 5'd5);
    tick();
    no_issue();
    repeat (5) tick();
    md_rdy = 1'b1; md_exception = 1'b1;
    tick();
    md_rdy = 1'b0; md_exception = 1'b0;
    tick();
    chk("mult_ovf_data", rv_data, 4);
    chk("mult_ovf_reg", rv_reg, 30);

    // watchdog timeout
    clr_obs();
    issue(1'b1, 1'b0, 32'd2, 32'd3, 5'd7);
    tick();
    no_issue();
    repeat (45) tick();
    chk("timeout_results", rv_cnt, 1);
    chk("timeout_data", rv_data, 7);
    chk("timeout_reg", rv_reg, 30);
    chk("timeout_latency", rv_cyc - pulse_cyc, 41);
    chk("timeout_stall_cycles", stall_cnt, 42);

    // flush in WAIT beats a same-cycle md_rdy; stray md_rdy afterwards is ignored
    clr_obs();
    issue(1'b0, 1'b1, 32'd9, 32'd3, 5'd8);
    tick();
    no_issue();
    repeat (3) tick();
    flush = 1'b1; md_rdy = 1'b1; md_result = 32'd3;
    tick();
    flush = 1'b0;
    chk("flush_idle", busy, 1'b0);
    repeat (3) tick();
    md_rdy = 1'b0;
    tick();
    chk("flush_results", rv_cnt, 0);
    chk("flush_pulses", pulse_cnt, 1);

    // back-to-back: second issue waiting while the first completes
    clr_obs();
    issue(1'b1, 1'b0, 32'd3, 32'd4, 5'd9);
    tick();
    no_issue();
    repeat (4) tick();
    md_rdy = 1'b1; md_result = 32'd12;
    issue(1'b0, 1'b1, 32'd20, 32'd5, 5'd10);
    tick();
    md_rdy = 1'b0;
    chk("b2b_first_data", result_data, 12);
    chk("b2b_done_no_stall", stall, 1'b0);
    tick();
    no_issue();
    chk("b2b_second_pulse", {ctrl_MULT, ctrl_DIV}, 2'b01);
    chk("b2b_second_a", md_a, 20);
    repeat (3) tick();
    md_rdy = 1'b1; md_result = 32'd4;
    tick();
    md_rdy = 1'b0;
    tick();
    chk("b2b_pulses", pulse_cnt, 2);
    chk("b2b_results", rv_cnt, 2);
    chk("b2b_data", rv_data, 4);
    chk("b2b_reg", rv_reg, 10);

    // reset during WAIT
    clr_obs();
    issue(1'b0, 1'b1, 32'd7, 32'd7, 5'd11);
    tick();
    no_issue();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk_all_zero("reset_mid_wait");
    reset = 1'b1;
    repeat (3) tick();
    chk("reset_no_result", rv_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
